// File: rtl/parking_pkg.sv
// Shared constants and types for the parking controller: password width,
// entry FSM encoding, debounce length and the downstream pass table.
package parking_pkg;

  localparam int unsigned CODE_BITS       = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned CAPACITY        = 8;

  // Pass table consumed by the downstream controller
  localparam logic [CODE_BITS-1:0] pass1 = 4'b1100;
  localparam logic [CODE_BITS-1:0] pass2 = 4'b1010;
  localparam logic [CODE_BITS-1:0] pass3 = 4'b0101;
  localparam logic [CODE_BITS-1:0] pass4 = 4'b0011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } entry_state_e;

endpackage

// File: rtl/button_debounce.sv
// One raw pushbutton: 2-FF synchroniser, debounce counter and a single-cycle
// pulse on each rising edge of the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = parking_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             stable_d_q;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], btn};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      stable_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Rising edge of the debounced level becomes a one-cycle press pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_q <= 1'b0;
      press      <= 1'b0;
    end else begin
      stable_d_q <= stable_q;
      press      <= stable_q & ~stable_d_q;
    end
  end

endmodule

// File: rtl/password_entry.sv
// Password entry front-end: debounces two pushbuttons, shifts one bit per
// clean press MSB-first and strobes code_valid when CODE_BITS bits are in.
// Optional build macro PASSWORD_TIMEOUT_EN adds an idle timeout that drops
// a partial entry after TIMEOUT_CYCLES cycles without an accepted press.
module password_entry #(
  parameter int unsigned CODE_BITS       = parking_pkg::CODE_BITS,
  parameter int unsigned DEBOUNCE_CYCLES = parking_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               pushbutton_0,
  input  logic                               pushbutton_1,
  output logic [CODE_BITS-1:0]               code,
  output logic                               code_valid,
  output logic [$clog2(CODE_BITS+1)-1:0]     digit_count,
  output logic                               busy,
  output logic                               entry_abort
);

  import parking_pkg::*;

  localparam int unsigned CNT_W = $clog2(CODE_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_BITS - 1);

  entry_state_e         state_q, state_n;
  logic [CODE_BITS-1:0] shreg_q, shreg_n, code_n;
  logic [CNT_W-1:0]     count_n;
  logic                 valid_n, abort_n;
  logic                 press0, press1;
  logic                 one_press_c, both_press_c, timeout_hit_c;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (pushbutton_0),
    .press   (press0)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (pushbutton_1),
    .press   (press1)
  );

  assign one_press_c  = press0 ^ press1;
  assign both_press_c = press0 & press1;

`ifdef PASSWORD_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;

  // Idle timer runs only while a partial entry is pending; any press restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                                          timer_q <= '0;
    else if (state_q != COLLECT || !busy || one_press_c || timeout_hit_c) timer_q <= '0;
    else                                                                   timer_q <= timer_q + TMR_W'(1);
  end

  assign timeout_hit_c = (state_q == COLLECT) && busy && (timer_q == TMR_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign timeout_hit_c      = 1'b0;
`endif

  // State and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      digit_count <= '0;
      busy        <= 1'b0;
      entry_abort <= 1'b0;
    end else begin
      state_q     <= state_n;
      shreg_q     <= shreg_n;
      code        <= code_n;
      code_valid  <= valid_n;
      digit_count <= count_n;
      busy        <= (count_n != '0);
      entry_abort <= abort_n;
    end
  end

  // Entry sequencing: collect bits, complete, or discard a partial entry
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    count_n = digit_count;
    code_n  = code;
    valid_n = 1'b0;
    abort_n = 1'b0;

    case (state_q)
      IDLE: begin
        shreg_n = '0;
        count_n = '0;
        if (enable) state_n = COLLECT;
      end

      COLLECT: begin
        if (!enable) begin
          abort_n = (digit_count != '0);
          shreg_n = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (both_press_c) begin
          abort_n = (digit_count != '0);
          shreg_n = '0;
          count_n = '0;
        end else if (one_press_c) begin
          shreg_n = {shreg_q[CODE_BITS-2:0], press1};
          count_n = digit_count + CNT_W'(1);
          if (digit_count == LAST_DIGIT) begin
            code_n  = shreg_n;
            valid_n = 1'b1;
            state_n = DONE;
          end
        end else if (timeout_hit_c) begin
          abort_n = 1'b1;
          shreg_n = '0;
          count_n = '0;
        end
      end

      DONE: begin
        shreg_n = '0;
        count_n = '0;
        state_n = enable ? COLLECT : IDLE;
      end

      default: begin
        shreg_n = '0;
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_password_entry.sv
// Randomised scoreboard bench for password_entry with a bit-list reference model.
module tb_password_entry;

  localparam int unsigned CB  = 4;
  localparam int unsigned DEB = 8;
  localparam int unsigned TMO = 200;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          pushbutton_0;
  logic          pushbutton_1;
  logic [CB-1:0] code;
  logic          code_valid;
  logic [2:0]    digit_count;
  logic          busy;
  logic          entry_abort;

  password_entry #(
    .CODE_BITS       (CB),
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pushbutton_0 (pushbutton_0),
    .pushbutton_1 (pushbutton_1),
    .code         (code),
    .code_valid   (code_valid),
    .digit_count  (digit_count),
    .busy         (busy),
    .entry_abort  (entry_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  bit lat_chk = 1'b0;
  bit prev_valid = 1'b0;

  // Reference model: bits entered so far, last completed code, expected events
  int m_cnt = 0;
  int m_code = 0;
  int last_code = 0;
  int exp_abort = 0;
  int exp_code_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input int b, input logic v);
    if (b != 0) pushbutton_1 = v;
    else        pushbutton_0 = v;
  endtask

  task automatic model_press(input int b);
    if (!enable) return;
    m_code = ((m_code << 1) | b) & ((1 << CB) - 1);
    m_cnt++;
    if (m_cnt == CB) begin
      exp_code_q.push_back(m_code);
      last_code = m_code;
      m_cnt = 0;
      m_code = 0;
    end
  endtask

  task automatic model_clear_partial();
    if (m_cnt != 0) exp_abort++;
    m_cnt = 0;
    m_code = 0;
  endtask

  // One press, optionally preceded by five 3-cycle bounces
  task automatic do_press(input int b, input bit bounce);
    if (bounce) begin
      repeat (5) begin
        set_raw(b, 1'b1); wait_cyc(3);
        set_raw(b, 1'b0); wait_cyc(3);
      end
    end
    set_raw(b, 1'b1);
    last_rise_cyc = cyc;
    model_press(b);
    wait_cyc(20);
    set_raw(b, 1'b0);
    wait_cyc(20);
  endtask

  task automatic do_both();
    pushbutton_0 = 1'b1;
    pushbutton_1 = 1'b1;
    if (enable) model_clear_partial();
    wait_cyc(20);
    pushbutton_0 = 1'b0;
    pushbutton_1 = 1'b0;
    wait_cyc(20);
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    model_clear_partial();
    wait_cyc(5);
    chk("enable_drop_digit_count", int'(digit_count), 0);
    enable = 1'b1;
    wait_cyc(3);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_digit_count"}, int'(digit_count), m_cnt);
    chk({tag, "_busy"}, int'(busy), int'(m_cnt != 0));
    chk({tag, "_code"}, int'(code), last_code);
  endtask

  // Monitor: pops expected codes and aborts whenever the DUT strobes them
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (code_valid) begin
        if (exp_code_q.size() == 0) fail("code_valid_unexpected", int'(code), -1);
        else                        chk("code", int'(code), exp_code_q.pop_front());
        chk("code_valid_single_pulse", int'(prev_valid), 0);
        if (lat_chk) chk("code_valid_latency", cyc - last_rise_cyc, DEB + 4);
      end
      if (entry_abort) begin
        if (exp_abort == 0) fail("entry_abort_unexpected", 1, 0);
        else begin
          exp_abort--;
          checks++;
        end
      end
    end
    prev_valid = code_valid;
  end

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    pushbutton_0 = 1'b0;
    pushbutton_1 = 1'b0;
    wait_cyc(3);
    chk("reset_code", int'(code), 0);
    chk("reset_code_valid", int'(code_valid), 0);
    chk("reset_digit_count", int'(digit_count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_entry_abort", int'(entry_abort), 0);
    reset_n = 1'b1;
    wait_cyc(2);
    enable = 1'b1;
    wait_cyc(3);

    // Clean entry 1,1,0,0 with count stepping and completion latency
    do_press(1, 1'b0); checkpoint("t1_p1");
    do_press(1, 1'b0); checkpoint("t1_p2");
    do_press(0, 1'b0); checkpoint("t1_p3");
    lat_chk = 1'b1;
    do_press(0, 1'b0);
    lat_chk = 1'b0;
    checkpoint("t1_done");
    chk("t1_code_1100", int'(code), 12);

    // Bouncy press counts once; a short glitch counts never
    do_press(1, 1'b1); checkpoint("t2_bounce");
    pushbutton_0 = 1'b1; wait_cyc(5);
    pushbutton_0 = 1'b0; wait_cyc(20);
    checkpoint("t2_glitch");

    // Enable drop discards a partial entry, then 1,0,1,0
    do_press(0, 1'b0); checkpoint("t3_p2");
    drop_enable();     checkpoint("t3_abort");
    do_press(1, 1'b0); do_press(0, 1'b0); do_press(1, 1'b0); do_press(0, 1'b0);
    checkpoint("t3_done");
    chk("t3_code_1010", int'(code), 10);

    // Simultaneous press aborts, then 0,1,0,1
    do_press(1, 1'b0);
    do_both();         checkpoint("t4_abort");
    do_both();         checkpoint("t4_idle_both");
    do_press(0, 1'b0); do_press(1, 1'b0); do_press(0, 1'b0); do_press(1, 1'b0);
    checkpoint("t4_done");
    chk("t4_code_0101", int'(code), 5);

    // Button held across the enable rise is not counted
    enable = 1'b0;
    wait_cyc(3);
    pushbutton_0 = 1'b1; wait_cyc(20);
    enable = 1'b1;       wait_cyc(20);
    checkpoint("t5_held");
    pushbutton_0 = 1'b0; wait_cyc(20);
    do_press(0, 1'b0);
    checkpoint("t5_repress");

    // Long idle with a partial entry
    do_press(1, 1'b0); do_press(0, 1'b0);
    checkpoint("t6_three");
`ifdef PASSWORD_TIMEOUT_EN
    model_clear_partial();
`endif
    wait_cyc(250);
    checkpoint("t6_idle");

    // Reset mid-entry clears everything immediately
    if (m_cnt == 0) do_press(1, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("rst_mid_code", int'(code), 0);
    chk("rst_mid_code_valid", int'(code_valid), 0);
    chk("rst_mid_digit_count", int'(digit_count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_entry_abort", int'(entry_abort), 0);
    m_cnt = 0;
    m_code = 0;
    last_code = 0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(3);
    checkpoint("rst_release");

    // Randomised presses, bounces, enable drops and simultaneous presses
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      drop_enable();
      else if (r == 1) do_both();
      else             do_press(int'($urandom_range(0, 1)), r < 6);
      checkpoint("rand");
    end

    wait_cyc(30);
    checkpoint("final");
    chk("pending_codes", exp_code_q.size(), 0);
    chk("pending_aborts", exp_abort, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
